// File: rtl/pvt_probe_scan_ctrl.sv
// Round-robin PVT probe scan sequencer: select/settle, start, await done or timeout, publish sample, sticky alarms.
// Latency: start SettleCycles+1 after scan decision, sample one cycle after done; no backpressure (sample strobe is fire-and-forget).
module pvt_probe_scan_ctrl #(
    parameter int NumProbes     = 8,
    parameter int DataWidth     = 10,
    parameter int SettleCycles  = 16,
    parameter int TimeoutCycles = 1024,
    parameter int IdxW          = $clog2(NumProbes)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_enable,
    input  logic [NumProbes-1:0] i_chan_mask,
    input  logic [DataWidth-1:0] i_thr_hi,
    output logic [IdxW-1:0]      o_probe_sel,
    output logic                 o_probe_sel_en,
    output logic                 o_conv_start,
    input  logic                 i_conv_done,
    input  logic [DataWidth-1:0] i_conv_data,
    output logic                 o_sample_valid,
    output logic [IdxW-1:0]      o_sample_chan,
    output logic [DataWidth-1:0] o_sample_data,
    output logic [NumProbes-1:0] o_alarm,
    input  logic [NumProbes-1:0] i_alarm_clr,
    output logic                 o_timeout_err,
    output logic [IdxW-1:0]      o_timeout_chan,
    input  logic                 i_err_clr,
    output logic                 o_busy
);

    localparam int CntMax = (TimeoutCycles > SettleCycles) ? TimeoutCycles : SettleCycles;
    localparam int CntW   = $clog2(CntMax + 1);

    typedef enum logic [2:0] {IDLE, SELECT, CONVERT, UPDATE, NEXT} state_t;

    state_t               state;
    logic [CntW-1:0]      cnt;
    logic [IdxW-1:0]      cur_chan;
    logic [IdxW-1:0]      nxt_chan;
    logic                 scan_go;
    logic                 conv_done_ok;
    logic                 timeout_hit;
    logic [NumProbes-1:0] alarm_set;

    // First set bit strictly after cur, wrapping; returns cur when it is the only set bit.
    function automatic logic [IdxW-1:0] next_chan(input logic [NumProbes-1:0] mask,
                                                  input logic [IdxW-1:0]      cur);
        logic [2*NumProbes-1:0] dbl;
        logic [NumProbes-1:0]   rot;
        int                     ofs;
        int                     sum;
        dbl = {mask, mask};
        rot = NumProbes'(dbl >> (int'(cur) + 1));
        ofs = 0;
        for (int i = NumProbes - 1; i >= 0; i--) begin
            if (rot[i]) ofs = i;
        end
        sum = int'(cur) + 1 + ofs;
        if (sum >= NumProbes) sum = sum - NumProbes;
        return IdxW'(sum);
    endfunction

    always_comb begin
        scan_go      = i_enable && (|i_chan_mask);
        nxt_chan     = next_chan(i_chan_mask, cur_chan);
        conv_done_ok = (state == CONVERT) && (cnt != '0) && i_conv_done;
        timeout_hit  = (state == CONVERT) && !conv_done_ok && (cnt == CntW'(TimeoutCycles));
        alarm_set    = '0;
        if (state == UPDATE && o_sample_data > i_thr_hi) alarm_set[o_sample_chan] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            cnt            <= '0;
            // Pointing at the top channel makes the first scan start at the lowest set bit.
            cur_chan       <= IdxW'(NumProbes - 1);
            o_probe_sel    <= '0;
            o_probe_sel_en <= 1'b0;
            o_conv_start   <= 1'b0;
            o_sample_valid <= 1'b0;
            o_sample_chan  <= '0;
            o_sample_data  <= '0;
            o_alarm        <= '0;
            o_timeout_err  <= 1'b0;
            o_timeout_chan <= '0;
            o_busy         <= 1'b0;
        end else begin
            o_conv_start   <= 1'b0;
            o_sample_valid <= 1'b0;
            o_alarm        <= (o_alarm & ~i_alarm_clr) | alarm_set;
            if (timeout_hit) begin
                o_timeout_err  <= 1'b1;
                o_timeout_chan <= cur_chan;
            end else if (i_err_clr) begin
                o_timeout_err  <= 1'b0;
            end

            case (state)
                IDLE, NEXT: begin
                    if (scan_go) begin
                        state          <= SELECT;
                        cnt            <= '0;
                        cur_chan       <= nxt_chan;
                        o_probe_sel    <= nxt_chan;
                        o_probe_sel_en <= 1'b1;
                        o_busy         <= 1'b1;
                    end else begin
                        state          <= IDLE;
                        o_probe_sel_en <= 1'b0;
                        o_busy         <= 1'b0;
                    end
                end
                SELECT: begin
                    if (cnt == CntW'(SettleCycles - 1)) begin
                        state        <= CONVERT;
                        cnt          <= '0;
                        o_conv_start <= 1'b1;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                CONVERT: begin
                    // cnt==0 marks the start cycle, where a done pulse is not accepted.
                    if (conv_done_ok) begin
                        state          <= UPDATE;
                        o_sample_valid <= 1'b1;
                        o_sample_chan  <= cur_chan;
                        o_sample_data  <= i_conv_data;
                    end else if (timeout_hit) begin
                        state <= NEXT;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                UPDATE:  state <= NEXT;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pvt_probe_scan_ctrl.sv
// Directed plus randomized bench for pvt_probe_scan_ctrl against a channel/timing/alarm reference model.
module tb_pvt_probe_scan_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst, i_enable, i_conv_done, i_err_clr;
    logic [7:0] i_chan_mask, i_alarm_clr;
    logic [9:0] i_thr_hi, i_conv_data;
    logic [2:0] o_probe_sel, o_sample_chan, o_timeout_chan;
    logic       o_probe_sel_en, o_conv_start, o_sample_valid, o_timeout_err, o_busy;
    logic [9:0] o_sample_data;
    logic [7:0] o_alarm;

    int         n_assert = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         n_samples = 0;
    int         last_samp_cyc;
    int         m_last;
    bit         m_first;
    logic [7:0] exp_alarm;

    pvt_probe_scan_ctrl #(.NumProbes(8), .DataWidth(10), .SettleCycles(16), .TimeoutCycles(1024)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_chan_mask(i_chan_mask),
        .i_thr_hi(i_thr_hi), .o_probe_sel(o_probe_sel), .o_probe_sel_en(o_probe_sel_en),
        .o_conv_start(o_conv_start), .i_conv_done(i_conv_done), .i_conv_data(i_conv_data),
        .o_sample_valid(o_sample_valid), .o_sample_chan(o_sample_chan), .o_sample_data(o_sample_data),
        .o_alarm(o_alarm), .i_alarm_clr(i_alarm_clr), .o_timeout_err(o_timeout_err),
        .o_timeout_chan(o_timeout_chan), .i_err_clr(i_err_clr), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        if (o_sample_valid === 1'b1) n_samples <= n_samples + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Next scanned channel: lowest set bit on a fresh scan, else first set bit after last (wrapping).
    function automatic int ref_next(input logic [7:0] mask, input int last, input bit first);
        int start;
        start = first ? 0 : last + 1;
        for (int off = 0; off < 8; off++) begin
            int c;
            c = (start + off) % 8;
            if (((mask >> c) & 8'd1) != 8'd0) return c;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_sel"},    32'(o_probe_sel), 0);
        check({tag, "_sel_en"}, 32'(o_probe_sel_en), 0);
        check({tag, "_start"},  32'(o_conv_start), 0);
        check({tag, "_svld"},   32'(o_sample_valid), 0);
        check({tag, "_schan"},  32'(o_sample_chan), 0);
        check({tag, "_sdata"},  32'(o_sample_data), 0);
        check({tag, "_alarm"},  32'(o_alarm), 0);
        check({tag, "_terr"},   32'(o_timeout_err), 0);
        check({tag, "_tchan"},  32'(o_timeout_chan), 0);
        check({tag, "_busy"},   32'(o_busy), 0);
    endtask

    task automatic wait_start(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (o_conv_start === 1'b1) seen = 1'b1;
            else tick();
        end
        check("start_seen", 32'(seen), 1);
    endtask

    // One conversion: expect start at exp_start on exp_ch, answer done at k, check sample and alarms.
    task automatic do_conv(input int exp_ch, input int k, input int data, input int exp_start,
                           input bit drop_en, input bit clr_upd, output int next_cyc);
        bit seen;
        int s0;
        bit over;
        i_conv_done = 1'b0;
        wait_start(seen);
        next_cyc = cyc;
        if (!seen) return;
        s0 = n_samples;
        check("start_cycle", cyc, exp_start);
        check("probe_sel", 32'(o_probe_sel), exp_ch);
        check("sel_en_conv", 32'(o_probe_sel_en), 1);
        check("busy_conv", 32'(o_busy), 1);
        i_conv_done = 1'b1;                   // must be ignored in the start cycle
        i_conv_data = 10'($urandom);
        if (drop_en) i_enable = 1'b0;
        tick();
        check("start_width", 32'(o_conv_start), 0);
        for (int j = 1; j <= k; j++) begin
            i_conv_done = (j == k);
            i_conv_data = (j == k) ? 10'(data) : 10'($urandom);
            tick();
        end
        i_conv_done = 1'b0;
        last_samp_cyc = cyc;
        check("sample_valid", 32'(o_sample_valid), 1);
        check("sample_chan", 32'(o_sample_chan), exp_ch);
        check("sample_data", 32'(o_sample_data), data);
        if (clr_upd) i_alarm_clr = 8'd1 << exp_ch;
        over = data > int'(i_thr_hi);
        exp_alarm = (exp_alarm & ~i_alarm_clr) | (over ? (8'd1 << exp_ch) : 8'd0);
        tick();
        i_alarm_clr = 8'd0;
        check("sample_single", 32'(o_sample_valid), 0);
        check("sample_count", n_samples, s0 + 1);
        check("alarm", 32'(o_alarm), 32'(exp_alarm));
        check("busy_next", 32'(o_busy), 1);
        m_last  = exp_ch;
        m_first = 1'b0;
        next_cyc = cyc;
    endtask

    initial begin
        int  nc, t0, c, s0, k, data, ch;
        bit  seen;
        i_rst = 1'b1; i_enable = 1'b0; i_chan_mask = 8'd0; i_thr_hi = 10'd0;
        i_conv_done = 1'b0; i_conv_data = 10'd0; i_alarm_clr = 8'd0; i_err_clr = 1'b0;
        tick(); tick(); tick();
        check_all_zero("reset");
        i_rst = 1'b0; m_first = 1'b1; m_last = 0; exp_alarm = 8'd0;
        tick();
        check("idle_busy", 32'(o_busy), 0);

        // Basic scan
        i_chan_mask = 8'b0000_0101; i_thr_hi = 10'd500; i_enable = 1'b1; t0 = cyc;
        do_conv(0, 3, 400, t0 + 17, 0, 0, nc);
        check("ch0_sample_latency", last_samp_cyc, t0 + 21);
        do_conv(2, 3, 600, nc + 17, 0, 0, nc);
        check("basic_alarm", 32'(o_alarm), 32'h04);
        i_enable = 1'b0;
        tick();
        check("stop_busy", 32'(o_busy), 0);
        check("stop_sel_en", 32'(o_probe_sel_en), 0);

        // Wrap from a fresh pointer
        i_rst = 1'b1; tick(); i_rst = 1'b0; m_first = 1'b1; exp_alarm = 8'd0;
        i_chan_mask = 8'b1000_0001; i_thr_hi = 10'($urandom); i_enable = 1'b1; nc = cyc;
        do_conv(0, $urandom_range(1, 5), $urandom_range(0, 1023), nc + 17, 0, 0, nc);
        do_conv(7, $urandom_range(1, 5), $urandom_range(0, 1023), nc + 17, 0, 0, nc);
        do_conv(0, $urandom_range(1, 5), $urandom_range(0, 1023), nc + 17, 0, 0, nc);
        i_enable = 1'b0; tick();

        // Single channel repeats back to back
        i_chan_mask = 8'b0001_0000; i_enable = 1'b1; nc = cyc;
        for (int r = 0; r < 3; r++)
            do_conv(4, $urandom_range(1, 5), $urandom_range(0, 1023), nc + 17, 0, 0, nc);
        i_enable = 1'b0; tick();

        // Timeout on ch3
        i_chan_mask = 8'b0000_1100; i_enable = 1'b1; nc = cyc;
        do_conv(ref_next(i_chan_mask, m_last, m_first), 2, $urandom_range(0, 1023), nc + 17, 0, 0, nc);
        i_conv_done = 1'b0;
        wait_start(seen);
        c = cyc; s0 = n_samples;
        check("to_start_cycle", c, nc + 17);
        check("to_chan_sel", 32'(o_probe_sel), 3);
        for (int i = 0; i < 1024; i++) tick();
        check("to_not_early", 32'(o_timeout_err), 0);
        tick();
        check("to_err", 32'(o_timeout_err), 1);
        check("to_chan", 32'(o_timeout_chan), 3);
        check("to_no_sample", n_samples, s0);
        m_last = 3; m_first = 1'b0; nc = cyc;
        i_conv_done = 1'b1; i_conv_data = 10'd1023; tick();
        i_conv_done = 1'b0; i_err_clr = 1'b1; tick();
        i_err_clr = 1'b0;
        check("err_clr", 32'(o_timeout_err), 0);
        check("stray_done_ignored", n_samples, s0);
        do_conv(ref_next(i_chan_mask, m_last, m_first), 1, $urandom_range(0, 1023), nc + 17, 0, 0, nc);
        i_enable = 1'b0; tick();

        // Stop mid-conversion, then resume after ch1
        i_chan_mask = 8'b0000_0110; i_enable = 1'b1; nc = cyc;
        do_conv(1, 4, $urandom_range(0, 1023), nc + 17, 1, 0, nc);
        tick();
        check("midstop_busy", 32'(o_busy), 0);
        check("midstop_sel_en", 32'(o_probe_sel_en), 0);
        tick(); tick();
        i_enable = 1'b1; nc = cyc;
        do_conv(2, 2, $urandom_range(0, 1023), nc + 17, 0, 0, nc);
        i_enable = 1'b0; i_alarm_clr = 8'hFF; exp_alarm = 8'd0; tick();
        i_alarm_clr = 8'd0;
        check("clr_all", 32'(o_alarm), 0);

        // Alarm set beats clear in the same cycle
        i_chan_mask = 8'b0000_0100; i_thr_hi = 10'd100; i_enable = 1'b1; nc = cyc;
        do_conv(2, 3, 900, nc + 17, 0, 1, nc);
        check("race_set_wins", 32'(o_alarm[2]), 1);
        i_enable = 1'b0; i_alarm_clr = 8'b0000_0100; exp_alarm = 8'd0; tick();
        i_alarm_clr = 8'd0;
        check("late_clr", 32'(o_alarm[2]), 0);

        // Reset in the start cycle
        i_chan_mask = 8'b0000_0010; i_enable = 1'b1;
        wait_start(seen);
        s0 = n_samples;
        i_rst = 1'b1; i_enable = 1'b0; tick();
        check_all_zero("midrst");
        i_rst = 1'b0; m_first = 1'b1; exp_alarm = 8'd0;
        i_conv_done = 1'b1; i_conv_data = 10'd1023; tick();
        i_conv_done = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("midrst_no_sample", n_samples, s0);
        check("midrst_idle", 32'(o_busy), 0);

        // Randomized scans, mask occasionally changed at the NEXT decision point
        for (int r = 0; r < 5; r++) begin
            i_chan_mask = 8'($urandom_range(1, 255));
            i_thr_hi = 10'($urandom);
            i_enable = 1'b1; nc = cyc;
            for (int j = 0; j < 4; j++) begin
                ch = ref_next(i_chan_mask, m_last, m_first);
                k = $urandom_range(1, 6);
                data = $urandom_range(0, 1023);
                do_conv(ch, k, data, nc + 17, 0, 0, nc);
                if ($urandom_range(0, 1) == 1) i_chan_mask = 8'($urandom_range(1, 255));
            end
            i_enable = 1'b0; tick();
            check("rand_idle", 32'(o_busy), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pvt_probe_scan_ctrl.md
# pvt_probe_scan_ctrl

Parametrised scan sequencer for a bank of remote PVT temperature probes. It sits between the analog probe-select mux of a multi-probe PVT sensor and that sensor's conversion interface. It round-robins over enabled probe channels, sequences settle, start and done for each conversion, and guards each conversion with a timeout. It publishes every sample with its channel index and raises per-channel sticky over-threshold alarms.

## Interface
Parameters:
- NumProbes, 8: number of remote probe channels; must be ≥2.
- DataWidth, 10: conversion result width.
- SettleCycles, 16: cycles the mux select is held before each start; must be ≥1.
- TimeoutCycles, 1024: maximum cycles to wait for conversion done.
- IdxW, $clog2(NumProbes): derived channel index width.

Ports:
- i_clk  in  1  block clock.
- i_rst  in  1  reset; one clock; reset is synchronous and active-high.
- i_enable  in  1  scan enable.
- i_chan_mask  in  NumProbes  channel enable mask; bit n enables probe n.
- i_thr_hi  in  DataWidth  alarm threshold, unsigned.
- o_probe_sel  out  IdxW  analog mux channel select.
- o_probe_sel_en  out  1  analog mux enable.
- o_conv_start  out  1  single-cycle conversion start pulse.
- i_conv_done  in  1  conversion complete, one-cycle pulse.
- i_conv_data  in  DataWidth  conversion result; valid with i_conv_done.
- o_sample_valid  out  1  single-cycle sample strobe.
- o_sample_chan  out  IdxW  channel of the current sample.
- o_sample_data  out  DataWidth  registered sample value.
- o_alarm  out  NumProbes  sticky per-channel over-threshold flags.
- i_alarm_clr  in  NumProbes  write-1-to-clear pulses for o_alarm.
- o_timeout_err  out  1  sticky timeout flag.
- o_timeout_chan  out  IdxW  channel of the most recent timeout.
- i_err_clr  in  1  clears o_timeout_err.
- o_busy  out  1  high whenever the state is not IDLE.

## Operation
The FSM has five states: IDLE, SELECT, CONVERT, UPDATE, NEXT.

- **IDLE**: If i_enable is high and i_chan_mask is non-zero, move to SELECT. The channel selected is the lowest set bit of the mask on the first scan. After a stop, scanning resumes at the next set bit after the last scanned channel.
- **SELECT**: o_probe_sel holds the channel and o_probe_sel_en is 1. A settle counter runs for SettleCycles cycles, then the FSM moves to CONVERT.
- **CONVERT**: o_conv_start is 1 in the first cycle only. i_conv_done is accepted only from the second CONVERT cycle onward. It is ignored in every other state and in the start cycle.
  - When i_conv_done is seen, latch i_conv_data and move to UPDATE.
  - If TimeoutCycles cycles pass after the start cycle with no done, set o_timeout_err, load o_timeout_chan, skip UPDATE and move to NEXT.
- **UPDATE**: o_sample_valid is 1 and o_sample_chan and o_sample_data are stable. Set o_alarm[chan] if data > i_thr_hi (strict compare, unsigned). Move to NEXT.
- **NEXT**: Sample i_enable and i_chan_mask.
  - If i_enable is low or the mask is zero, go to IDLE.
  - Otherwise pick the next set bit strictly after the current channel, wrapping modulo NumProbes, and go to SELECT.
  - If only the current channel is set, reselect it.
- A mask or enable change is sampled only in IDLE and NEXT. An in-flight channel always completes.
- Alarm set and clear of the same bit in the same cycle: set wins. The same rule applies to timeout set versus i_err_clr.

## Timing
- Reset values: state IDLE, and o_probe_sel, o_probe_sel_en, o_conv_start, o_sample_valid, o_sample_chan, o_sample_data, o_alarm, o_timeout_err, o_timeout_chan and o_busy all 0. The resume pointer is reset so the next scan starts at the lowest set bit.
- Every output is registered.
- Reset asserted mid-operation aborts immediately. If it falls in the start cycle, o_conv_start is 0 in the following cycle, and no sample or alarm is produced.
- Enable seen high in IDLE at cycle T: SELECT runs in cycles T+1 through T+SettleCycles, and o_conv_start is 1 at C = T+SettleCycles+1.
- Done seen at C+k (k≥1): o_sample_valid at C+k+1, NEXT at C+k+2, next SELECT starts at C+k+3.
- Timeout: NEXT at C+TimeoutCycles+1, and the o_timeout_err rise is visible in that same cycle.
- o_probe_sel_en is high from SELECT through NEXT, and low only in IDLE.
- o_alarm updates in the cycle after UPDATE. i_alarm_clr takes effect on the next cycle.

## Test plan
- **Basic scan**: NumProbes=8, SettleCycles=16, mask 8'b0000_0101, thr 10'd500. Done returns at k=3 with data 400 then 600. Required: samples (ch0,400) then (ch2,600); o_alarm=8'b0000_0100; sample_valid for ch0 exactly 21 cycles after enable high.
- **Wrap and single channel**: mask 8'b1000_0001 gives sequence ch0, ch7, ch0. Mask 8'b0001_0000 gives ch4 repeated with no gap beyond the NEXT cycle.
- **Timeout**: TimeoutCycles=1024, no done for ch3. Required: o_timeout_err=1 and o_timeout_chan=3 at C+1025, no sample_valid, scan proceeds to the next channel. A done arriving afterwards is ignored.
- **Stop mid-conversion**: i_enable dropped during CONVERT of ch1. Required: the ch1 sample is still emitted, then IDLE with o_busy=0. Re-enabling resumes at the next set bit after ch1.
- **Clear versus set race**: i_alarm_clr[2]=1 in the same cycle as a ch2 over-threshold update. Required: o_alarm[2] stays 1. A clear in a later cycle gives 0.
- **Reset mid-operation**: i_rst during the start cycle. Required: all outputs 0 on the next cycle, and no sample is emitted for a done pulse that follows.
